dsp48a1_mac_sequencer: RTL and testbench
========================================

DSP48A1_MAC_SEQUENCER -- requirements
Module: dsp48a1_mac_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning slice operand-to-P latency (A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, A0REG=B0REG=0).
REQ-002 SHALL have parameter LENW, default 16, meaning element-count width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid/s_ready  input/output  1/1  operand handshake.
REQ-006 s_a, s_b  input  18 each  signed operand pair.
REQ-007 s_last  input  1  marks final element of a vector.
REQ-008 m_valid/m_ready  output/input  1/1  result handshake.
REQ-009 m_p  output  48  signed dot-product result.
REQ-010 m_carry  output  1  slice CARRYOUT sampled with m_p.
REQ-011 m_len  output  LENW  elements in the result's vector.
REQ-012 dsp_a, dsp_b  output  18 each  to slice A, B (B_INPUT DIRECT).
REQ-013 dsp_opmode  output  8  to slice OPMODE.
REQ-014 dsp_ce  output  1  drives all slice clock enables.
REQ-015 dsp_p, dsp_carryout  input  48/1  from slice P, CARRYOUT.

Function
REQ-016 States: IDLE, ACCUM, DRAIN, RESULT; one vector in flight.
REQ-017 s_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN and RESULT.
REQ-018 Handshake (s_valid&s_ready) at cycle t: dsp_a=s_a, dsp_b=s_b same cycle; dsp_a/dsp_b otherwise 0.
REQ-019 dsp_opmode at t+1: 8'h01 (X=M, Z=0) if element first of vector, 8'h09 (X=M, Z=P) otherwise; bits 4-7 always 0.
REQ-020 Any cycle not following a handshake, dsp_opmode SHALL be 8'h08 (X=0, Z=P) so P holds; s_valid gaps are legal.
REQ-021 IDLE->ACCUM on handshake without s_last; IDLE or ACCUM->DRAIN on handshake with s_last.
REQ-022 DRAIN SHALL count LAT cycles after last handshake, capture dsp_p, dsp_carryout, element count into m_p, m_carry, m_len on that edge, enter RESULT.
REQ-023 RESULT: m_valid=1, outputs stable until m_ready; on m_valid&m_ready go IDLE, m_valid=0 next cycle.
REQ-024 m_valid SHALL rise exactly LAT+1 cycles after last-element handshake cycle.
REQ-025 Element counter SHALL saturate at all-ones; restarts at 1 on first element.
REQ-026 Accumulation is modulo 2^48; no saturation.
REQ-027 dsp_ce SHALL be 1 whenever rst_n=1.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, s_ready=1 after release, m_valid=0, m_p=0, m_carry=0, m_len=0, dsp_a=dsp_b=0, dsp_opmode=8'h00, dsp_ce=0.
REQ-029 Reset mid-vector SHALL discard the partial result; next vector's first element uses Z=0, so no slice reset is needed.

Configuration
REQ-030 With DSP_SEQ_STATS_EN defined: outputs stat_results (32, results accepted) and stat_stalls (32, cycles m_valid&!m_ready), wrapping, reset to 0.
REQ-031 Without DSP_SEQ_STATS_EN: both outputs exist, tied to 0, no counter logic.

Structure
REQ-032 Shared package dsp_pkg SHALL hold state enum and opmode constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_HOLD=8'h08.
REQ-033 One sub-module dsp_seq_tagpipe: LAT-deep valid/first/last shift register timing opmode and capture.

Verification
REQ-034 Single element a=3, b=4, last=1 at cycle 0 -> m_valid at cycle 4, m_p=12, m_len=1.
REQ-035 a=-2 (18'h3FFFE), b=5, last -> m_p=48'hFFFF_FFFF_FFF6.
REQ-036 Vector a=b={1,2,3,4}, 2-cycle gaps between elements -> m_p=30, m_len=4; dsp_opmode=8'h08 in gap cycles.
REQ-037 m_ready low 5 cycles in RESULT -> m_p stable, s_ready=0 throughout, stat_stalls=5 when DSP_SEQ_STATS_EN.
REQ-038 rst_n low mid-ACCUM after 2 elements, then vector {5}x{6} -> m_p=30, m_len=1.
REQ-039 Two back-to-back vectors {2}x{2}, {7}x{3} -> results 4 then 21, no contamination.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared sequencer state encoding and DSP48A1 OPMODE constants
package dsp_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;
  // OPMODE[1:0] is the X mux (01 = M), OPMODE[3:2] is the Z mux (10 = P)
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
endpackage

// File: rtl/dsp_seq_tagpipe.sv
// dsp_seq_tagpipe: LAT-deep valid/last tag pipe plus first tag, aligning OPMODE and P capture with the slice
module dsp_seq_tagpipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_first,
  input  logic in_last,
  output logic op_valid,
  output logic op_first,
  output logic cap
);
  logic [LAT-1:0] valid;
  logic [LAT-1:0] last;
  logic first;
  // Stage k holds the tags of the element handshaken k+1 cycles ago
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      last  <= '0;
      first <= 1'b0;
    end else begin
      valid[0] <= in_valid;
      last[0]  <= in_valid & in_last;
      first    <= in_first;
      for (int i = 1; i < LAT; i++) begin
        valid[i] <= valid[i-1];
        last[i]  <= last[i-1];
      end
    end
  assign op_valid = valid[0];
  assign op_first = first;
  assign cap      = valid[LAT-1] & last[LAT-1];
endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer: streams operand pairs into a DSP48A1 slice and returns dot products; DSP_SEQ_STATS_EN adds result/stall counters
module dsp48a1_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int LAT  = 3,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [17:0]     s_a,
  input  logic [17:0]     s_b,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [47:0]     m_p,
  output logic            m_carry,
  output logic [LENW-1:0] m_len,
  output logic [17:0]     dsp_a,
  output logic [17:0]     dsp_b,
  output logic [7:0]      dsp_opmode,
  output logic            dsp_ce,
  input  logic [47:0]     dsp_p,
  input  logic            dsp_carryout,
  output logic [31:0]     stat_results,
  output logic [31:0]     stat_stalls
);
  state_t state;
  logic [LENW-1:0] count;
  logic hs, op_valid, op_first, cap;

  assign s_ready    = rst_n && (state == IDLE || state == ACCUM);
  assign hs         = s_valid && s_ready;
  assign dsp_a      = hs ? s_a : '0;
  assign dsp_b      = hs ? s_b : '0;
  assign dsp_ce     = rst_n;
  assign dsp_opmode = !rst_n ? 8'h00 : !op_valid ? OPM_HOLD : op_first ? OPM_FIRST : OPM_ACC;

  dsp_seq_tagpipe #(.LAT(LAT)) tagpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (hs),
    .in_first (state == IDLE),
    .in_last  (s_last),
    .op_valid (op_valid),
    .op_first (op_first),
    .cap      (cap)
  );

  // Vector FSM: count elements, wait for the last product to reach P, hold the result until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      m_valid <= 1'b0;
      m_p     <= '0;
      m_carry <= 1'b0;
      m_len   <= '0;
    end else begin
      if (hs) count <= (state == IDLE) ? LENW'(1) : (&count ? count : count + 1'b1);
      case (state)
        IDLE, ACCUM: if (hs) state <= s_last ? DRAIN : ACCUM;
        DRAIN: if (cap) begin
          state   <= RESULT;
          m_valid <= 1'b1;
          m_p     <= dsp_p;
          m_carry <= dsp_carryout;
          m_len   <= count;
        end
        default: if (m_ready) begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end

`ifdef DSP_SEQ_STATS_EN
  // Wrapping counters of accepted results and back-pressured result cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_results <= '0;
      stat_stalls  <= '0;
    end else begin
      if (m_valid && m_ready) stat_results <= stat_results + 1'b1;
      if (m_valid && !m_ready) stat_stalls <= stat_stalls + 1'b1;
    end
`else
  assign stat_results = '0;
  assign stat_stalls  = '0;
`endif
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb_dsp48a1_mac_sequencer: DSP48A1 slice stand-in plus dot-product reference model, directed and random vectors
module tb_dsp48a1_mac_sequencer;
  localparam int LAT  = 3;
  localparam int LENW = 16;

  logic clk = 1'b0;
  logic rst_n, s_valid, s_ready, s_last, m_valid, m_ready, m_carry, dsp_ce, dsp_carryout;
  logic [17:0] s_a, s_b, dsp_a, dsp_b;
  logic [47:0] m_p, dsp_p;
  logic [LENW-1:0] m_len;
  logic [7:0] dsp_opmode;
  logic [31:0] stat_results, stat_stalls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp48a1_mac_sequencer #(.LAT(LAT), .LENW(LENW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a          (s_a),
    .s_b          (s_b),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_p          (m_p),
    .m_carry      (m_carry),
    .m_len        (m_len),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_ce       (dsp_ce),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .stat_results (stat_results),
    .stat_stalls  (stat_stalls)
  );

  // Slice stand-in: A1/B1, M, OPMODE and P registers, X/Z post-adder with carry out
  logic [17:0] a1 = '0, b1 = '0;
  logic signed [35:0] mreg = '0;
  logic [7:0] opr = '0;
  logic [47:0] preg = '0;
  logic cout = 1'b0;
  always @(posedge clk)
    if (dsp_ce) begin
      a1   <= dsp_a;
      b1   <= dsp_b;
      mreg <= $signed(a1) * $signed(b1);
      opr  <= dsp_opmode;
      {cout, preg} <= {1'b0, (opr[1:0] == 2'b01) ? {{12{mreg[35]}}, mreg} : 48'd0}
                    + {1'b0, (opr[3:2] == 2'b10) ? preg : 48'd0};
    end
  assign dsp_p = preg;
  assign dsp_carryout = cout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model state: dot product of the current vector and the pending result
  int cyc = 0, due = 0, len = 0, exp_len = 0, exp_res = 0, exp_stl = 0;
  int rise_cyc = 0, last_hs_cyc = 0;
  logic busy = 1'b0, infirst = 1'b1, prev_hs = 1'b0, prev_first = 1'b0, prev_mv = 1'b0;
  logic [47:0] acc = '0, exp_p = '0;
  logic acc_c = 1'b0, exp_c = 1'b0;
  logic [47:0] got_p[$];
  int got_len[$];

  always @(negedge clk) begin
    logic hs, exp_mv;
    logic signed [35:0] pr;
    logic [48:0] sum;
    cyc++;
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_p", m_p, 0);
      chk("rst_m_carry", m_carry, 0);
      chk("rst_m_len", m_len, 0);
      chk("rst_dsp_a", dsp_a, 0);
      chk("rst_dsp_b", dsp_b, 0);
      chk("rst_opmode", dsp_opmode, 8'h00);
      chk("rst_ce", dsp_ce, 0);
      chk("rst_stat_results", stat_results, 0);
      chk("rst_stat_stalls", stat_stalls, 0);
      busy = 0; infirst = 1; prev_hs = 0; prev_mv = 0; exp_res = 0; exp_stl = 0;
    end else begin
      exp_mv = busy && cyc >= due;
      hs = s_valid && !busy;
      chk("s_ready", s_ready, !busy);
      chk("dsp_ce", dsp_ce, 1);
      chk("dsp_a", dsp_a, hs ? s_a : 18'd0);
      chk("dsp_b", dsp_b, hs ? s_b : 18'd0);
      chk("dsp_opmode", dsp_opmode, prev_hs ? (prev_first ? 8'h01 : 8'h09) : 8'h08);
      chk("m_valid", m_valid, exp_mv);
      if (exp_mv) begin
        chk("m_p", m_p, exp_p);
        chk("m_carry", m_carry, exp_c);
        chk("m_len", m_len, exp_len);
      end
`ifdef DSP_SEQ_STATS_EN
      chk("stat_results", stat_results, exp_res);
      chk("stat_stalls", stat_stalls, exp_stl);
`else
      chk("stat_results", stat_results, 0);
      chk("stat_stalls", stat_stalls, 0);
`endif
      if (m_valid && !prev_mv) rise_cyc = cyc;
      prev_mv = m_valid;
      if (exp_mv && m_ready) begin
        got_p.push_back(m_p);
        got_len.push_back(int'(m_len));
        busy = 0;
        exp_res++;
      end
      if (exp_mv && !m_ready) exp_stl++;
      prev_hs = hs;
      prev_first = infirst;
      if (hs) begin
        if (infirst) begin
          acc = '0;
          len = 0;
        end
        pr = $signed(s_a) * $signed(s_b);
        sum = {1'b0, acc} + {1'b0, {{12{pr[35]}}, pr}};
        acc = sum[47:0];
        acc_c = sum[48];
        len = (len == (1 << LENW) - 1) ? len : len + 1;
        infirst = 0;
        if (s_last) begin
          busy = 1;
          due = cyc + LAT + 1;
          exp_p = acc;
          exp_c = acc_c;
          exp_len = len;
          infirst = 1;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_garbage();
    tick();
    s_valid = 1'($urandom_range(0, 1));
    s_a = 18'($urandom);
    s_b = 18'($urandom);
    s_last = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int a, input int b, input bit last, input int gap);
    s_valid = 0;
    repeat (gap) tick();
    s_valid = 1; s_a = 18'(a); s_b = 18'(b); s_last = last;
    tick();
    s_valid = 0; s_last = 0; s_a = 0; s_b = 0;
  endtask

  // Waits for m_valid, holds m_ready low for 'stall' result cycles, then accepts
  task automatic wait_result(input int stall);
    int n = 0;
    m_ready = 0;
    forever begin
      @(negedge clk);
      if (m_valid) break;
      if (++n > 40) begin
        checks++; errors++;
        $display("FAIL wait_result: m_valid 0 after 40 cycles, required 1");
        break;
      end
      tick_garbage();
    end
    for (int i = 1; i < stall; i++) tick_garbage();
    tick();
    m_ready = 1; s_valid = 0; s_last = 0; s_a = 0; s_b = 0;
    tick();
    m_ready = 0;
  endtask

  task automatic expect_res(input string n, input logic [47:0] p, input int l);
    if (got_p.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no result, required m_p %h", n, p);
    end else begin
      chk({n, "_p"}, got_p.pop_front(), p);
      chk({n, "_len"}, got_len.pop_front(), l);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; s_valid = 0; s_a = 0; s_b = 0; s_last = 0; m_ready = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    send(3, 4, 1, 0);
    wait_result(5);
    expect_res("single_3x4", 48'd12, 1);
    chk("single_latency", rise_cyc - last_hs_cyc, LAT + 1);
`ifdef DSP_SEQ_STATS_EN
    chk("stall_count", stat_stalls, 5);
`endif
    send(-2, 5, 1, 0);
    wait_result(1);
    expect_res("neg_2x5", 48'hFFFF_FFFF_FFF6, 1);
    for (int i = 1; i <= 4; i++) send(i, i, i == 4, 2);
    wait_result(1);
    expect_res("gapped_1234", 48'd30, 4);
    send(1, 1, 0, 0);
    send(2, 2, 0, 0);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    send(5, 6, 1, 0);
    wait_result(1);
    expect_res("after_reset", 48'd30, 1);
    send(2, 2, 1, 0);
    wait_result(1);
    send(7, 3, 1, 0);
    wait_result(2);
    expect_res("b2b_first", 48'd4, 1);
    expect_res("b2b_second", 48'd21, 1);
    send(-131072, -131072, 0, 0);
    send(131071, 131071, 1, 0);
    wait_result(1);
    expect_res("extremes", 48'd34359476225, 2);
    for (int v = 0; v < 40; v++) begin
      int n = $urandom_range(1, 6);
      for (int e = 0; e < n; e++) send(int'($urandom), int'($urandom), e == n - 1, $urandom_range(0, 2));
      wait_result($urandom_range(1, 3));
    end
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
